// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mem_stage_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/dm_array.sv
// Single-port synchronous word RAM; read data is registered on the access edge
// and held until the next read, so writes never disturb it.
module dm_array
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_q[idx];
        end
    end

endmodule

// File: rtl/mem_stage_dm.sv
// MEM-stage data-memory responder: latches an aligned request, stalls the pipe
// for LATENCY+1 cycles, then pulses ack with the access complete.
module mem_stage_dm
    import mem_stage_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              ack_o,
    output logic              misalign_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY) + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              ack_q, ack_d;
    logic              mis_q, mis_d;
    logic              arr_we, arr_re;
    logic              req, aligned;

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:IDX_W+2];

    assign req     = MemRead_i | MemWrite_i;
    assign aligned = (addr_i[1:0] == 2'b00);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_READ;
            idx_q   <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        mis_d   = 1'b0;
        stall_o = 1'b0;
        arr_we  = 1'b0;
        arr_re  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !aligned) begin
                    mis_d = 1'b1;
                end else if (req) begin
                    stall_o = 1'b1;
                    op_d    = MemWrite_i ? OP_WRITE : OP_READ;
                    idx_d   = addr_i[IDX_W+1:2];
                    wdata_d = wdata_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Reset in the final BUSY cycle must abort, not commit, the write.
                    arr_we  = (op_q == OP_WRITE) && !rst_i;
                    arr_re  = (op_q == OP_READ) && !rst_i;
                    ack_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dm_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_dm_array (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (rdata_o)
    );

    assign ack_o      = ack_q;
    assign misalign_o = mis_q;

endmodule
